// File: rtl/muldiv_unit_if.sv
// Handshake and result bus for the multiply/divide unit.
// The master side issues operations and cancels them; the slave side (the unit)
// reports busy/done and drives the HI/LO write enables and result.
interface muldiv_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [1:0]  we;
   logic [63:0] hilo_out;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  busy, done, we, hilo_out
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output busy, done, we, hilo_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit producing a 64-bit {HI, LO} result.
// Operations: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Multiplies use shift-add and
// divides use restoring shift-subtract, both on operand magnitudes, one bit per
// cycle for 32 cycles, followed by a sign-fix cycle and a one-cycle DONE pulse.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a
// single-cycle 32x32 multiplier (IDLE->FIX->DONE); divides are unaffected.
module muldiv_unit (
   input  logic           clk,
   input  logic           rst,
   muldiv_unit_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] aux_q;
   logic [4:0]  cnt_q;
   logic        isMul_q;
   logic        negQ_q;
   logic        negR_q;
   logic        busy_q;
   logic        done_q;
   logic [1:0]  we_q;
   logic [63:0] hilo_q;

   logic        signedOp;
   logic [31:0] magA;
   logic [31:0] magB;
   logic [32:0] mulSum;
   logic [32:0] divShift;
   logic [32:0] divDiff;
   logic [31:0] stepHi_d;
   logic [31:0] stepLo_d;
   logic [63:0] fixResult_d;
`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fastProd;
`endif

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.we       = we_q;
   assign bus.hilo_out = hilo_q;

   // Operand magnitudes for the signed ops; the sign is restored in FIX.
   always_comb begin
      signedOp = ~bus.op[0];
      magA     = (signedOp && bus.src_a[31]) ? -bus.src_a : bus.src_a;
      magB     = (signedOp && bus.src_b[31]) ? -bus.src_b : bus.src_b;
`ifdef MULDIV_FAST_MUL_EN
      fastProd = {32'd0, magA} * {32'd0, magB};
`endif
   end

   // One radix-2 step: {hi,lo} is the product/multiplier pair for multiplies and
   // the remainder/dividend-quotient pair for divides; aux holds the other operand.
   always_comb begin
      mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, aux_q} : 33'd0);
      divShift = {hi_q, lo_q[31]};
      divDiff  = divShift - {1'b0, aux_q};
      stepHi_d = hi_q;
      stepLo_d = lo_q;
      if (isMul_q) begin
         stepHi_d = mulSum[32:1];
         stepLo_d = {mulSum[0], lo_q[31:1]};
      end else if (!divDiff[32]) begin
         stepHi_d = divDiff[31:0];
         stepLo_d = {lo_q[30:0], 1'b1};
      end else begin
         stepHi_d = divShift[31:0];
         stepLo_d = {lo_q[30:0], 1'b0};
      end
   end

   // Sign correction: negate the whole product, or quotient and remainder separately.
   always_comb begin
      fixResult_d = {hi_q, lo_q};
      if (isMul_q) begin
         if (negQ_q) fixResult_d = -{hi_q, lo_q};
      end else begin
         fixResult_d = {(negR_q ? -hi_q : hi_q), (negQ_q ? -lo_q : lo_q)};
      end
   end

   // Control FSM with registered busy/done/we and the held result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         aux_q   <= '0;
         cnt_q   <= '0;
         isMul_q <= 1'b0;
         negQ_q  <= 1'b0;
         negR_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 2'b00;
         hilo_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.cancel) begin
                  isMul_q <= ~bus.op[1];
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  if (bus.op[1]) begin
                     if (bus.src_b == 32'd0) begin
                        hi_q    <= bus.src_a;
                        lo_q    <= 32'hFFFF_FFFF;
                        aux_q   <= '0;
                        negQ_q  <= 1'b0;
                        negR_q  <= 1'b0;
                        state_q <= FIX;
                     end else begin
                        hi_q    <= '0;
                        lo_q    <= magA;
                        aux_q   <= magB;
                        negQ_q  <= signedOp & (bus.src_a[31] ^ bus.src_b[31]);
                        negR_q  <= signedOp & bus.src_a[31];
                        state_q <= RUN;
                     end
                  end else begin
                     negQ_q <= signedOp & (bus.src_a[31] ^ bus.src_b[31]);
                     negR_q <= 1'b0;
                     aux_q  <= magA;
`ifdef MULDIV_FAST_MUL_EN
                     hi_q    <= fastProd[63:32];
                     lo_q    <= fastProd[31:0];
                     state_q <= FIX;
`else
                     hi_q    <= '0;
                     lo_q    <= magB;
                     state_q <= RUN;
`endif
                  end
               end
            end
            RUN: begin
               if (bus.cancel) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  hi_q  <= stepHi_d;
                  lo_q  <= stepLo_d;
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) state_q <= FIX;
               end
            end
            FIX: begin
               if (bus.cancel) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  hilo_q  <= fixResult_d;
                  done_q  <= 1'b1;
                  we_q    <= 2'b11;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               we_q    <= 2'b00;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               we_q    <= 2'b00;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed operations against a plain
// arithmetic model of the results and a cycle-count model of busy/done/we.
module tb_muldiv_unit;

   logic clk;
   logic rst;
   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

`ifdef MULDIV_FAST_MUL_EN
   localparam int MulLat = 2;
`else
   localparam int MulLat = 34;
`endif

   int          nChecks = 0;
   int          nFail   = 0;
   int          cnt     = 0;
   bit          mActive = 0;
   int          mS      = 0;
   int          mLat    = 0;
   logic [63:0] mRes    = '0;
   logic [63:0] mLast   = '0;

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to time operations from the edge that sampled start.
   always @(posedge clk) cnt <= cnt + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cnt, act, exp);
      end
   endtask

   function automatic logic [63:0] modelResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (o)
         2'b00: res = sa * sb;
         2'b01: res = {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (o == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   function automatic int opLatency(input logic [1:0] o, input logic [31:0] b);
      if (!o[1]) return MulLat;
      return (b == 32'd0) ? 2 : 34;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin : compareProc
      logic        expBusy;
      logic        expDone;
      logic [1:0]  expWe;
      logic [63:0] expHilo;
      expBusy = mActive;
      expDone = 1'b0;
      expWe   = 2'b00;
      expHilo = mLast;
      if (mActive && (cnt - mS + 1) == mLat) begin
         expDone = 1'b1;
         expWe   = 2'b11;
         expHilo = mRes;
         mLast   = mRes;
         mActive = 0;
      end
      checkOutput("busy", {63'd0, bus.busy}, {63'd0, expBusy});
      checkOutput("done", {63'd0, bus.done}, {63'd0, expDone});
      checkOutput("we", {62'd0, bus.we}, {62'd0, expWe});
      checkOutput("hilo_out", bus.hilo_out, expHilo);
   end

   // Issue one operation while the unit is idle and register it with the model.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk); #1;
      bus.start = 1'b1;
      bus.op    = o;
      bus.src_a = a;
      bus.src_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      mActive   = 1;
      mS        = cnt;
      mLat      = opLatency(o, b);
      mRes      = modelResult(o, a, b);
   endtask

   // Wait (bounded) for done; check latency and optionally a hand-computed result.
   task automatic waitDone(input string name, input bit useLit, input logic [63:0] litHilo, input int litLat);
      int  n;
      bit  seen;
      int  expLat;
      seen   = 0;
      expLat = (litLat > 0) ? litLat : mLat;
      for (n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1;
      end
      if (!seen) begin
         checkOutput({name, " done timeout"}, 64'd0, 64'd1);
      end else begin
         checkOutput({name, " latency"}, 64'(cnt - mS + 1), 64'(expLat));
         if (useLit) begin
            checkOutput({name, " hilo literal"}, bus.hilo_out, litHilo);
            checkOutput({name, " we literal"}, {62'd0, bus.we}, 64'd3);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      bus.op     = 2'b00;
      bus.src_a  = '0;
      bus.src_b  = '0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("reset done", {63'd0, bus.done}, 64'd0);
      checkOutput("reset we", {62'd0, bus.we}, 64'd0);
      checkOutput("reset hilo", bus.hilo_out, 64'd0);
      rst = 1'b0;

      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDone("MULTU max", 1, 64'hFFFF_FFFE_0000_0001, MulLat);
      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5);
      waitDone("MULT -3x5", 1, 64'hFFFF_FFFF_FFFF_FFF1, 0);
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
      waitDone("DIV -7/2", 1, 64'hFFFF_FFFF_FFFF_FFFD, 34);
      applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone("DIV overflow", 1, 64'h0000_0000_8000_0000, 0);
      applyStimulus(2'b11, 32'd100, 32'd0);
      waitDone("DIVU by zero", 1, 64'h0000_0064_FFFF_FFFF, 2);
      applyStimulus(2'b10, 32'hFFFF_FFF8, 32'd0);
      waitDone("DIV by zero", 1, 64'hFFFF_FFF8_FFFF_FFFF, 2);
      applyStimulus(2'b11, 32'd1000, 32'd7);
      waitDone("DIVU 1000/7", 1, 64'h0000_0006_0000_008E, 0);
      applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE);
      waitDone("DIV 7/-2", 1, 64'h0000_0001_FFFF_FFFD, 0);
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
      waitDone("DIV -7/-2", 1, 64'hFFFF_FFFF_0000_0003, 0);
      applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000);
      waitDone("MULT min*min", 1, 64'h4000_0000_0000_0000, 0);
      applyStimulus(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      waitDone("MULTU mixed", 0, 64'd0, 0);
      applyStimulus(2'b00, 32'h0001_0000, 32'hFFFF_0000);
      waitDone("MULT neg", 0, 64'd0, 0);

      // Start while busy must be ignored.
      applyStimulus(2'b11, 32'd1000, 32'd7);
      repeat (4) @(negedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.src_a = 32'd3;
      bus.src_b = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      waitDone("start while busy", 1, 64'h0000_0006_0000_008E, 34);

      // Start together with cancel in IDLE must not start anything.
      @(negedge clk); #1;
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      bus.op     = 2'b11;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("start+cancel idle busy", {63'd0, bus.busy}, 64'd0);

      // Cancel in cycle 10 of a DIVU, then an immediate new operation.
      applyStimulus(2'b11, 32'hDEAD_BEEF, 32'd3);
      while (cnt != mS + 9) @(negedge clk);
      #1;
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      mActive    = 0;
      checkOutput("cancel busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("cancel hilo", bus.hilo_out, mLast);
      applyStimulus(2'b11, 32'd50, 32'd6);
      waitDone("after cancel", 1, 64'h0000_0002_0000_0008, 34);

      // Reset pulse in cycle 20 of a MULT.
      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5);
      while (cnt != mS + 19) @(negedge clk);
      #1;
      rst     = 1'b1;
      mActive = 0;
      mLast   = '0;
      #1;
      checkOutput("rst busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("rst hilo", bus.hilo_out, 64'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (40) @(negedge clk);

      applyStimulus(2'b01, 32'd7, 32'd6);
      waitDone("after reset", 1, 64'd42, 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: operation request; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-005 SHALL have ports src_a and src_b, input, 32 bits each: multiplicand/multiplier or dividend/divisor; sampled with start.
REQ-006 SHALL have port cancel, input, 1 bit: abort of the in-flight operation.
REQ-007 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port we, output, 2 bits: HI/LO write enables (bit1 HI, bit0 LO), driving the HI/LO register file.
REQ-010 SHALL have port hilo_out, output, 64 bits: {HI, LO} result, driving the HI/LO register file data input.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX and DONE.
REQ-012 IDLE with start=1 and cancel=0 SHALL latch op and operands, clear the step counter, and enter RUN (or FIX per REQ-014 and REQ-018).
REQ-013 RUN SHALL perform one radix-2 step per cycle for exactly 32 cycles:
  - multiply: shift-add on operand magnitudes;
  - divide: restoring shift-subtract on operand magnitudes;
  - then enter FIX.
REQ-014 A divide with src_b=0 SHALL bypass RUN (IDLE->FIX).
REQ-015 FIX SHALL apply sign correction for signed ops and form the 64-bit result, then enter DONE.
REQ-016 DONE SHALL, for exactly one cycle, assert done=1, we=2'b11 and present the valid hilo_out, then enter IDLE.
REQ-017 Latency SHALL be fixed: done is high in the 34th cycle after the edge that sampled start (2nd cycle for divide-by-zero bypass).
REQ-018 MULT/MULTU SHALL produce the full 64-bit signed/unsigned product in {HI, LO}.
REQ-019 DIV/DIVU SHALL produce LO=quotient and HI=remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-021 Divide by zero SHALL yield HI=src_a and LO=0xFFFFFFFF for both DIV and DIVU.
REQ-022 start while busy SHALL be ignored; latched operands are unaffected.
REQ-023 cancel=1 in RUN or FIX SHALL return to IDLE at the next edge with no done/we pulse and hilo_out unchanged.
REQ-024 cancel in DONE SHALL have no effect.
REQ-025 start and cancel both high in IDLE SHALL not start an operation.
REQ-026 hilo_out SHALL hold the last completed result while not in DONE.
REQ-027 we SHALL be 2'b00 and done SHALL be 0 outside DONE.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and clear counter and operand registers, with outputs busy=0, done=0, we=2'b00, hilo_out=0.
REQ-029 rst asserted mid-operation SHALL discard the operation with no write pulse.

Configuration
REQ-030 Macro MULDIV_FAST_MUL_EN, when defined, SHALL compute MULT/MULTU with a single-cycle 32x32 multiplier (IDLE->FIX->DONE; done in the 2nd cycle after start).
  - Divide behaviour SHALL be unchanged.
REQ-031 When MULDIV_FAST_MUL_EN is undefined, multiplies SHALL use the 32-step iterative path of REQ-013, with 34-cycle latency.

Verification
REQ-032 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hilo_out=0xFFFFFFFE_00000001, we=11 and done in cycle 34 (cycle 2 with macro).
REQ-033 SHALL cover: MULT 0xFFFFFFFD (-3) x 5 -> hilo_out=0xFFFFFFFF_FFFFFFF1.
REQ-034 SHALL cover: DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL cover: DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, done in cycle 2.
REQ-036 SHALL cover: cancel in cycle 10 of DIVU -> busy=0 next cycle, no done/we, hilo_out unchanged; a new start the following cycle completes normally.
REQ-037 SHALL cover: rst pulsed in cycle 20 of MULT -> busy=0 and hilo_out=0 immediately, no we pulse afterwards.
